pc_sequencer: RTL

//   Owns the fetch PC and sequences its redirection. Takes redirect requests

---
 rtl/pc_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch PC owner: advances the PC, applies trap/branch redirects and squashes
// wrong-path IF/ID work for a fixed bubble window after each redirect.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_vector,
  input  logic        stall,
  input  logic        fetch_ready,
  output logic [31:0] pc_out,
  output logic        fetch_valid,
  output logic        flush_if,
  output logic        flush_id,
  output logic        misalign_pulse,
  output logic [15:0] flush_count
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [2:0] BUBBLE_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state_r,    state_next_s;
  logic [31:0] pc_r,       pc_next_s;
  logic [2:0]  bubble_r,   bubble_next_s;
  logic        flush_r,    flush_next_s;
  logic        misalign_r, misalign_next_s;
  logic [15:0] count_r,    count_next_s;
  logic        fetch_valid_s;
  logic        enter_flush_s;

  assign fetch_valid_s  = (state_r == RUN) && !stall;
  assign fetch_valid    = fetch_valid_s;
  assign pc_out         = pc_r;
  assign flush_if       = flush_r;
  assign flush_id       = flush_r;
  assign misalign_pulse = misalign_r;
  assign flush_count    = count_r;

  // State and output registers; reset also aborts any flush in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= RUN;
      pc_r       <= RESET_PC;
      bubble_r   <= 3'd0;
      flush_r    <= 1'b0;
      misalign_r <= 1'b0;
      count_r    <= 16'd0;
    end else begin
      state_r    <= state_next_s;
      pc_r       <= pc_next_s;
      bubble_r   <= bubble_next_s;
      flush_r    <= flush_next_s;
      misalign_r <= misalign_next_s;
      count_r    <= count_next_s;
    end
  end

  // Next-state logic: redirect priority in RUN, bubble countdown in FLUSH.
  always_comb begin
    state_next_s    = state_r;
    pc_next_s       = pc_r;
    bubble_next_s   = bubble_r;
    flush_next_s    = flush_r;
    misalign_next_s = 1'b0;
    count_next_s    = count_r;
    enter_flush_s   = 1'b0;
    case (state_r)
      RUN: begin
        if (trap_valid) begin
          pc_next_s     = trap_vector;
          enter_flush_s = 1'b1;
        end else if (redirect_valid && (redirect_target[1:0] == 2'b00)) begin
          pc_next_s     = redirect_target;
          enter_flush_s = 1'b1;
        end else if (redirect_valid) begin
          // Misaligned branch target is turned into a trap to the vector.
          pc_next_s       = trap_vector;
          misalign_next_s = 1'b1;
          enter_flush_s   = 1'b1;
        end else if (fetch_valid_s && fetch_ready) begin
          pc_next_s = pc_r + 32'd4;
        end else begin
          pc_next_s = pc_r;
        end
        if (enter_flush_s) begin
          state_next_s  = FLUSH;
          bubble_next_s = BUBBLE_LOAD;
          flush_next_s  = 1'b1;
          count_next_s  = (count_r == 16'hFFFF) ? count_r : count_r + 16'd1;
        end else begin
          state_next_s = RUN;
          flush_next_s = 1'b0;
        end
      end
      FLUSH: begin
        if (bubble_r == 3'd0) begin
          state_next_s = RUN;
          flush_next_s = 1'b0;
        end else begin
          bubble_next_s = bubble_r - 3'd1;
        end
      end
      default: begin
        state_next_s = RUN;
        flush_next_s = 1'b0;
      end
    endcase
  end

endmodule
